// File: rtl/dcache_pkg.sv
// Purpose: shared types and constants for the data-cache line-transfer controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package dcache_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_CMD,
        S_WB_ADDR,
        S_WB_DATA,
        S_WB_GAP,
        S_RD_CMD,
        S_RD_ADDR,
        S_RD_DUMMY,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [3:0] CMD_WRITE = 4'h2;
    localparam logic [3:0] CMD_READ  = 4'hB;

    // Address nibbles sent per command: the byte address rounded up to whole nibbles.
    function automatic int addr_nibs(input int pa);
        return (pa + 3) / 4;
    endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Purpose: bundle of cache-side and serial-memory-side signals of the line-transfer controller.
// Ports: cache lookup/victim inputs, fill/drain strobes, stall, and the 4-bit memory bus (qcs/qout/qoe/qin).
// Modports: master = cache + memory environment, slave = controller.
interface dcache_mem_if #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22
);
    localparam int LA_W = PA - $clog2(LINE_LENGTH);

    logic            req;
    logic            fault;
    logic [LA_W-1:0] paddr_line;
    logic            hit;
    logic            push;
    logic            pull;
    logic [LA_W-1:0] tag;
    logic [3:0]      dwrite;
    logic [3:0]      dread;
    logic            wstrobe_d;
    logic            rstrobe_d;
    logic            stall;
    logic            qcs;
    logic [3:0]      qout;
    logic            qoe;
    logic [3:0]      qin;

    modport master (
        output req, fault, paddr_line, hit, push, pull, tag, dwrite, qin,
        input  dread, wstrobe_d, rstrobe_d, stall, qcs, qout, qoe
    );

    modport slave (
        input  req, fault, paddr_line, hit, push, pull, tag, dwrite, qin,
        output dread, wstrobe_d, rstrobe_d, stall, qcs, qout, qoe
    );

endinterface

// File: rtl/dcache_mem.sv
// Purpose: on a cache miss, stall the core, write back a dirty victim and fill the line over a 4-bit serial memory bus.
// Latency: clean miss 21 cycles from miss to stall release; dirty miss adds 16 cycles.
// Backpressure: none on the memory bus (fixed timing); the CPU is held via combinational stall.
module dcache_mem
    import dcache_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22,
    parameter int RD_DUMMY    = 4
) (
    input  logic         clk,
    input  logic         reset,
    dcache_mem_if.slave  bus
);

    localparam int OFF_W     = $clog2(LINE_LENGTH);
    localparam int LA_W      = PA - OFF_W;
    localparam int ADDR_NIBS = addr_nibs(PA);
    localparam int AW        = 4 * ADDR_NIBS;
    localparam int LINE_NIBS = 2 * LINE_LENGTH;
    localparam int MAX_AD    = (ADDR_NIBS > RD_DUMMY) ? ADDR_NIBS : RD_DUMMY;
    localparam int CNT_MAX   = (MAX_AD > LINE_NIBS) ? MAX_AD : LINE_NIBS;
    localparam int CW        = $clog2(CNT_MAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LA_W-1:0] fill_q, fill_d;

    logic miss;
    logic last;

    // Line address -> zero-extended byte address as sent on the wire.
    function automatic logic [AW-1:0] byte_addr(input logic [LA_W-1:0] la);
        logic [AW-1:0] r;
        r         = '0;
        r[PA-1:0] = {la, {OFF_W{1'b0}}};
        return r;
    endfunction

    // Dwell time of each state, loaded into the counter on entry.
    function automatic logic [CW-1:0] dwell(input state_t s);
        case (s)
            S_WB_ADDR, S_RD_ADDR: return CW'(ADDR_NIBS);
            S_RD_DUMMY:           return CW'(RD_DUMMY);
            S_WB_DATA, S_RD_DATA: return CW'(LINE_NIBS);
            S_IDLE:               return '0;
            default:              return CW'(1);
        endcase
    endfunction

    assign miss = bus.req && bus.pull && !bus.fault;
    assign last = (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        addr_d  = addr_q;
        fill_d  = fill_q;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    fill_d = bus.paddr_line;
                    if (bus.push) begin
                        addr_d  = byte_addr(bus.tag);
                        state_d = S_WB_CMD;
                    end else begin
                        addr_d  = byte_addr(bus.paddr_line);
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_WB_CMD:   if (last) state_d = S_WB_ADDR;
            S_WB_ADDR: begin
                addr_d = addr_q << 4;
                if (last) state_d = S_WB_DATA;
            end
            S_WB_DATA:  if (last) state_d = S_WB_GAP;
            S_WB_GAP: begin
                // Victim address has been shifted out; reload with the fill line.
                if (last) begin
                    addr_d  = byte_addr(fill_q);
                    state_d = S_RD_CMD;
                end
            end
            S_RD_CMD:   if (last) state_d = S_RD_ADDR;
            S_RD_ADDR: begin
                addr_d = addr_q << 4;
                if (last) state_d = S_RD_DUMMY;
            end
            S_RD_DUMMY: if (last) state_d = S_RD_DATA;
            S_RD_DATA:  if (last) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = dwell(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs decode directly from state so an async reset silences them at once.
    always_comb begin
        bus.qcs       = 1'b1;
        bus.qoe       = 1'b0;
        bus.qout      = 4'h0;
        bus.rstrobe_d = 1'b0;
        bus.wstrobe_d = 1'b0;
        bus.dread     = 4'h0;
        case (state_q)
            S_IDLE, S_WB_GAP, S_DONE: bus.qcs = 1'b0;
            S_WB_CMD: begin
                bus.qoe  = 1'b1;
                bus.qout = CMD_WRITE;
            end
            S_RD_CMD: begin
                bus.qoe  = 1'b1;
                bus.qout = CMD_READ;
            end
            S_WB_ADDR, S_RD_ADDR: begin
                bus.qoe  = 1'b1;
                bus.qout = addr_q[AW-1 -: 4];
            end
            S_WB_DATA: begin
                bus.qoe       = 1'b1;
                bus.qout      = bus.dwrite;
                bus.rstrobe_d = 1'b1;
            end
            S_RD_DATA: begin
                bus.wstrobe_d = 1'b1;
                bus.dread     = bus.qin;
            end
            default: ;
        endcase
        bus.stall = (state_q != S_IDLE) || miss;
    end

endmodule

// File: tb/tb_dcache_mem.sv
// Purpose: directed self-checking bench for dcache_mem (miss fill, dirty write-back, fault, hit, reset abort, back-to-back).
// Latency: inputs driven just after each falling edge, outputs checked 1 time unit later.
// Backpressure: none; memory nibbles are supplied on a fixed cycle schedule.
module tb_dcache_mem;
    import dcache_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dcache_mem_if #(.LINE_LENGTH(4), .PA(22)) bus ();

    dcache_mem #(.LINE_LENGTH(4), .PA(22), .RD_DUMMY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // RD_CMD, address nibbles (MSB first) and dummy cycles.
    task automatic rd_head(input logic [23:0] a);
        tick(); #1;
        chk("rd_cmd_qout", 32'(bus.qout), 32'hB);
        chk("rd_cmd_qoe",  32'(bus.qoe),  32'h1);
        chk("rd_cmd_qcs",  32'(bus.qcs),  32'h1);
        chk("rd_cmd_stall", 32'(bus.stall), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            chk("rd_addr_qout", 32'(bus.qout), 32'(a[23-4*i -: 4]));
            chk("rd_addr_qoe",  32'(bus.qoe),  32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("rd_dummy_qoe", 32'(bus.qoe), 32'h0);
            chk("rd_dummy_qcs", 32'(bus.qcs), 32'h1);
            chk("rd_dummy_wstb", 32'(bus.wstrobe_d), 32'h0);
        end
    endtask

    // Eight fill nibbles base, base+1, ... then DONE; the cache side updates pull/paddr during DONE.
    task automatic rd_tail(input logic [3:0] base, input logic nxt_pull, input logic [19:0] nxt_paddr);
        logic [3:0] nib;
        for (int k = 0; k < 8; k++) begin
            tick();
            nib = base + 4'(k);
            bus.qin = nib;
            #1;
            chk("rd_data_wstb",  32'(bus.wstrobe_d), 32'h1);
            chk("rd_data_dread", 32'(bus.dread),     32'(nib));
            chk("rd_data_qoe",   32'(bus.qoe),       32'h0);
        end
        tick();
        bus.qin        = 4'h0;
        bus.pull       = nxt_pull;
        bus.paddr_line = nxt_paddr;
        #1;
        chk("done_qcs",   32'(bus.qcs),       32'h0);
        chk("done_wstb",  32'(bus.wstrobe_d), 32'h0);
        chk("done_stall", 32'(bus.stall),     32'h1);
    endtask

    logic [31:0] wb_pat;
    logic [23:0] wb_addr;
    logic [3:0]  nib;

    initial begin
        bus.req = 0; bus.fault = 0; bus.paddr_line = '0; bus.hit = 0;
        bus.push = 0; bus.pull = 0; bus.tag = '0; bus.dwrite = 4'h0; bus.qin = 4'hF;
        wb_pat  = 32'hFECA9753;
        wb_addr = 24'h000040;

        // Reset state; qin driven non-zero to show dread is gated.
        #3;
        chk("rst_qcs",   32'(bus.qcs),       32'h0);
        chk("rst_qoe",   32'(bus.qoe),       32'h0);
        chk("rst_qout",  32'(bus.qout),      32'h0);
        chk("rst_wstb",  32'(bus.wstrobe_d), 32'h0);
        chk("rst_rstb",  32'(bus.rstrobe_d), 32'h0);
        chk("rst_dread", 32'(bus.dread),     32'h0);
        chk("rst_stall", 32'(bus.stall),     32'h0);
        repeat (2) tick();
        reset = 1'b1;

        // Hit: no transfer.
        tick(); bus.req = 1; bus.pull = 0; bus.hit = 1; #1;
        chk("hit_stall", 32'(bus.stall), 32'h0);
        chk("hit_qcs",   32'(bus.qcs),   32'h0);
        tick(); #1;
        chk("hit_qcs2",  32'(bus.qcs),   32'h0);

        // Fault with pull: no transfer, no stall.
        tick(); bus.hit = 0; bus.pull = 1; bus.fault = 1; #1;
        chk("fault_stall", 32'(bus.stall), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("fault_qcs",   32'(bus.qcs),       32'h0);
            chk("fault_wstb",  32'(bus.wstrobe_d), 32'h0);
            chk("fault_rstb",  32'(bus.rstrobe_d), 32'h0);
            chk("fault_stall", 32'(bus.stall),     32'h0);
        end
        tick(); bus.fault = 0; bus.req = 0; bus.pull = 0; #1;

        // Clean miss on line 0x12345 -> byte address 0x048D14.
        tick(); bus.req = 1; bus.pull = 1; bus.paddr_line = 20'h12345; #1;
        chk("clean_c0_stall", 32'(bus.stall), 32'h1);
        chk("clean_c0_qcs",   32'(bus.qcs),   32'h0);
        rd_head(24'h048D14);
        rd_tail(4'h1, 1'b0, 20'h12345);
        tick(); #1;
        chk("clean_c21_stall", 32'(bus.stall), 32'h1 - 32'h1);
        chk("clean_c21_qcs",   32'(bus.qcs),   32'h0);

        // Dirty miss: victim 0x00010 written back, then fill of 0x2AAAA.
        tick(); bus.pull = 1; bus.push = 1; bus.tag = 20'h00010; bus.paddr_line = 20'h2AAAA; #1;
        chk("dirty_c0_stall", 32'(bus.stall), 32'h1);
        tick(); #1;
        chk("wb_cmd_qout", 32'(bus.qout), 32'h2);
        chk("wb_cmd_qoe",  32'(bus.qoe),  32'h1);
        chk("wb_cmd_qcs",  32'(bus.qcs),  32'h1);
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            chk("wb_addr_qout", 32'(bus.qout), 32'(wb_addr[23-4*i -: 4]));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            nib = wb_pat[4*i +: 4];
            bus.dwrite = nib;
            #1;
            chk("wb_data_rstb", 32'(bus.rstrobe_d), 32'h1);
            chk("wb_data_qout", 32'(bus.qout),      32'(nib));
            chk("wb_data_qoe",  32'(bus.qoe),       32'h1);
        end
        tick(); bus.push = 0; bus.dwrite = 4'h0; #1;
        chk("wb_gap_qcs",  32'(bus.qcs),       32'h0);
        chk("wb_gap_rstb", 32'(bus.rstrobe_d), 32'h0);
        chk("wb_gap_qoe",  32'(bus.qoe),       32'h0);
        rd_head(24'h0AAAA8);
        rd_tail(4'h7, 1'b0, 20'h2AAAA);
        tick(); #1;
        chk("dirty_c37_stall", 32'(bus.stall), 32'h0);

        // Async reset in RD_DATA cycle 3 of a fill of line 0x00001.
        tick(); bus.pull = 1; bus.paddr_line = 20'h00001; #1;
        rd_head(24'h000004);
        for (int k = 0; k < 3; k++) begin
            tick(); bus.qin = 4'(k + 1); #1;
            chk("abort_pre_wstb", 32'(bus.wstrobe_d), 32'h1);
        end
        tick(); bus.qin = 4'h4; #1;
        chk("abort_c3_wstb", 32'(bus.wstrobe_d), 32'h1);
        reset = 1'b0; bus.req = 0; bus.pull = 0; #1;
        chk("abort_wstb",  32'(bus.wstrobe_d), 32'h0);
        chk("abort_qcs",   32'(bus.qcs),       32'h0);
        chk("abort_qoe",   32'(bus.qoe),       32'h0);
        chk("abort_dread", 32'(bus.dread),     32'h0);
        chk("abort_qout",  32'(bus.qout),      32'h0);
        chk("abort_stall", 32'(bus.stall),     32'h0);
        tick(); #1;
        chk("abort_hold_wstb", 32'(bus.wstrobe_d), 32'h0);
        chk("abort_hold_qcs",  32'(bus.qcs),       32'h0);
        reset = 1'b1; bus.qin = 4'h0;

        // Restart of the aborted miss, flowing straight into a back-to-back miss on 0x3FFFF.
        tick(); bus.req = 1; bus.pull = 1; #1;
        chk("restart_c0_stall", 32'(bus.stall), 32'h1);
        chk("restart_c0_qcs",   32'(bus.qcs),   32'h0);
        rd_head(24'h000004);
        rd_tail(4'h1, 1'b1, 20'h3FFFF);
        tick(); #1;
        chk("b2b_c0_stall", 32'(bus.stall), 32'h1);
        chk("b2b_c0_qcs",   32'(bus.qcs),   32'h0);
        rd_head(24'h0FFFFC);
        rd_tail(4'h9, 1'b0, 20'h3FFFF);
        tick(); #1;
        chk("b2b_end_stall", 32'(bus.stall), 32'h0);
        bus.req = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
